// File: rtl/msk_demodulator.sv
// MSK receive demodulator: recovers one byte per frame of offset-binary samples.
// Optional energy squelch with sticky erasure flag: define MSK_DEMOD_SQUELCH_EN.
module msk_demodulator #(
    parameter int SAMPLES_PER_BIT = 32,
    parameter int BITS_PER_BYTE   = 8,
    parameter int MID             = 128,
    parameter int ACC_W           = 14
`ifdef MSK_DEMOD_SQUELCH_EN
    ,
    parameter int SQ_THRESH       = 512
`endif
) (
    input  logic                     G_CLK_RX,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     sample_valid,
    input  logic [7:0]               sample_in,
    output logic [BITS_PER_BYTE-1:0] data_out,
    output logic                     data_valid,
    output logic                     busy,
    output logic                     erasure
);
    localparam int CNT_W = $clog2(SAMPLES_PER_BIT);
    localparam int BIT_W = (BITS_PER_BYTE > 1) ? $clog2(BITS_PER_BYTE) : 1;
    localparam logic [CNT_W-1:0] HALF   = CNT_W'(SAMPLES_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_S = CNT_W'(SAMPLES_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_B = BIT_W'(BITS_PER_BYTE - 1);

    typedef enum logic [1:0] {IDLE, ACQ, DONE} state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  s1_q, s1_d;
    logic signed [ACC_W-1:0]  s2_q, s2_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BIT_W-1:0]         bit_q, bit_d;
    logic [BITS_PER_BYTE-1:0] shift_q, shift_d;
    logic [BITS_PER_BYTE-1:0] data_q, data_d;
    logic                     er_q, er_d;

    logic signed [8:0]        diff;
    logic signed [ACC_W-1:0]  d_ext;
    logic signed [ACC_W-1:0]  s2_fin;
    logic                     restart;
    logic                     low_energy;
    logic                     sym_bit;

    assign diff    = 9'(int'({1'b0, sample_in}) - MID);
    assign d_ext   = {{(ACC_W-9){diff[8]}}, diff};
    assign s2_fin  = s2_q + d_ext;
    assign restart = start && sample_valid && (state_q != DONE);

`ifdef MSK_DEMOD_SQUELCH_EN
    localparam logic [ACC_W:0] THR = (ACC_W+1)'(SQ_THRESH);
    logic [ACC_W-1:0] abs1, abs2;
    logic [ACC_W:0]   energy;

    assign abs1       = s1_q[ACC_W-1] ? ACC_W'(-s1_q) : s1_q;
    assign abs2       = s2_fin[ACC_W-1] ? ACC_W'(-s2_fin) : s2_fin;
    assign energy     = {1'b0, abs1} + {1'b0, abs2};
    assign low_energy = energy < THR;
`else
    assign low_energy = 1'b0;
`endif

    // Same sign of both half-sums means a half cycle, i.e. a '1'.
    assign sym_bit = (s1_q[ACC_W-1] == s2_fin[ACC_W-1]) && !low_energy;

    always_comb begin
        state_d = state_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        er_d    = er_q;
        if (restart) begin
            state_d = ACQ;
            s1_d    = d_ext;
            s2_d    = '0;
            cnt_d   = CNT_W'(1);
            bit_d   = '0;
            shift_d = '0;
            er_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                ACQ: begin
                    if (sample_valid) begin
                        if (cnt_q < HALF) begin
                            s1_d  = s1_q + d_ext;
                            cnt_d = cnt_q + CNT_W'(1);
                        end else if (cnt_q != LAST_S) begin
                            s2_d  = s2_fin;
                            cnt_d = cnt_q + CNT_W'(1);
                        end else begin
                            shift_d[bit_q] = sym_bit;
                            er_d  = er_q | low_energy;
                            s1_d  = '0;
                            s2_d  = '0;
                            cnt_d = '0;
                            bit_d = bit_q + BIT_W'(1);
                            if (bit_q == LAST_B) begin
                                state_d = DONE;
                                data_d  = shift_d;
                            end
                        end
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge G_CLK_RX) begin
        if (!reset) begin
            state_q <= IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            er_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            er_q    <= er_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = (state_q == DONE);
    assign busy       = (state_q == ACQ);
    assign erasure    = er_q;

endmodule
